// File: rtl/cache_pkg.sv
// Shared cache message encodings: FSM bus operations and L2-to-L1 messages.
// NULL / NULLMsg mark "nothing emitted" and are never queued.
package cache_pkg;

    typedef enum logic [2:0] {
        NULL       = 3'd0,
        READ       = 3'd1,
        WRITE      = 3'd2,
        INVALIDATE = 3'd3,
        RWIM       = 3'd4
    } bus_struct;

    typedef enum logic [2:0] {
        NULLMsg        = 3'd0,
        GETLINE        = 3'd1,
        SENDLINE       = 3'd2,
        INVALIDATELINE = 3'd3,
        EVICTLINE      = 3'd4
    } l2tol1_struct;

    localparam int OP_W = 3;

endpackage

// File: rtl/cache_msg_queue_if.sv
// Event input and the two drained output channels of the message queue.
// The producer/consumer side uses master; the queue itself uses slave.
interface cache_msg_queue_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
);
    import cache_pkg::*;

    logic              evt_valid;
    logic [ADDR_W-1:0] evt_addr;
    bus_struct         bus_func_in;
    l2tol1_struct      l2tol1msg_in;

    logic              bus_out_valid;
    logic              bus_out_ready;
    bus_struct         bus_out_op;
    logic [ADDR_W-1:0] bus_out_addr;

    logic              l1_out_valid;
    logic              l1_out_ready;
    l2tol1_struct      l1_out_msg;
    logic [ADDR_W-1:0] l1_out_addr;

    logic              bus_full;
    logic              l1_full;
    logic [CNT_W-1:0]  bus_drops;
    logic [CNT_W-1:0]  l1_drops;

    modport master (
        output evt_valid, evt_addr, bus_func_in, l2tol1msg_in,
        output bus_out_ready, l1_out_ready,
        input  bus_out_valid, bus_out_op, bus_out_addr,
        input  l1_out_valid, l1_out_msg, l1_out_addr,
        input  bus_full, l1_full, bus_drops, l1_drops
    );

    modport slave (
        input  evt_valid, evt_addr, bus_func_in, l2tol1msg_in,
        input  bus_out_ready, l1_out_ready,
        output bus_out_valid, bus_out_op, bus_out_addr,
        output l1_out_valid, l1_out_msg, l1_out_addr,
        output bus_full, l1_full, bus_drops, l1_drops
    );

endinterface

// File: rtl/cache_msg_fifo.sv
// First-word fall-through FIFO with occupancy count and a saturating counter
// of pushes discarded because the FIFO was full.
module cache_msg_fifo #(
    parameter int DW    = 35,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [DW-1:0]    data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [DW-1:0]    data_o,
    output logic             full_o,
    output logic [CNT_W-1:0] drops_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW:0]      occ_q, occ_d;
    logic [CNT_W-1:0] drops_q, drops_d;
    logic             doPush, doPop, doDrop;

    // A pop on the same edge frees the slot, so push+pop while full is legal.
    always_comb begin
        doPop   = pop_i && (occ_q != '0);
        doPush  = push_i && ((occ_q != FULL_OCC) || doPop);
        doDrop  = push_i && !doPush;
        wrPtr_d = doPush ? wrPtr_q + PW'(1) : wrPtr_q;
        rdPtr_d = doPop  ? rdPtr_q + PW'(1) : rdPtr_q;
        case ({doPush, doPop})
            2'b10:   occ_d = occ_q + (PW+1)'(1);
            2'b01:   occ_d = occ_q - (PW+1)'(1);
            default: occ_d = occ_q;
        endcase
        drops_d = (doDrop && (drops_q != '1)) ? drops_q + CNT_W'(1) : drops_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            occ_q   <= '0;
            drops_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            occ_q   <= occ_d;
            drops_q <= drops_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

    assign valid_o = (occ_q != '0);
    assign full_o  = (occ_q == FULL_OCC);
    assign data_o  = mem_q[rdPtr_q];
    assign drops_o = drops_q;

endmodule

// File: rtl/cache_msg_queue.sv
// Queues MESI FSM bus operations and L2-to-L1 messages into two independent
// channels, dropping NULL entries and presenting fixed idle values when empty.
module cache_msg_queue
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input logic              clk,
    input logic              rst,
    cache_msg_queue_if.slave q
);

    localparam int DW = OP_W + ADDR_W;

    logic          busPush, l1Push;
    logic          busValid, l1Valid;
    logic [DW-1:0] busHead, l1Head;

    assign busPush = q.evt_valid && (q.bus_func_in != NULL);
    assign l1Push  = q.evt_valid && (q.l2tol1msg_in != NULLMsg);

    cache_msg_fifo #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) busFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (busPush),
        .data_i  ({q.bus_func_in, q.evt_addr}),
        .pop_i   (q.bus_out_ready),
        .valid_o (busValid),
        .data_o  (busHead),
        .full_o  (q.bus_full),
        .drops_o (q.bus_drops)
    );

    cache_msg_fifo #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) l1Fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (l1Push),
        .data_i  ({q.l2tol1msg_in, q.evt_addr}),
        .pop_i   (q.l1_out_ready),
        .valid_o (l1Valid),
        .data_o  (l1Head),
        .full_o  (q.l1_full),
        .drops_o (q.l1_drops)
    );

    // Storage is not cleared by reset, so an empty channel must mask its head.
    assign q.bus_out_valid = busValid;
    assign q.bus_out_op    = busValid ? bus_struct'(busHead[DW-1 -: OP_W]) : NULL;
    assign q.bus_out_addr  = busValid ? busHead[ADDR_W-1:0] : '0;

    assign q.l1_out_valid  = l1Valid;
    assign q.l1_out_msg    = l1Valid ? l2tol1_struct'(l1Head[DW-1 -: OP_W]) : NULLMsg;
    assign q.l1_out_addr   = l1Valid ? l1Head[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_cache_msg_queue.sv
// Self-checking bench for cache_msg_queue: a per-channel queue scoreboard
// plus scenario tasks with targeted checks; CNT_W=2 makes saturation cheap.
module tb_cache_msg_queue;
    import cache_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 2;
    localparam int MAX_DROPS = (1 << CNT_W) - 1;

    typedef struct {bus_struct op; logic [ADDR_W-1:0] addr;} busEnt_t;
    typedef struct {l2tol1_struct msg; logic [ADDR_W-1:0] addr;} l1Ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_msg_queue_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) qif ();

    cache_msg_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .q   (qif)
    );

    busEnt_t busQ[$];
    l1Ent_t  l1Q[$];
    int      busDrops, l1Drops;
    int      vecCount, missCount;

    // Called at a negedge: drive one cycle, score the current outputs, advance the model.
    task automatic step(input logic ev, input logic [ADDR_W-1:0] a, input bus_struct bop,
                        input l2tol1_struct lm, input logic bRdy, input logic lRdy);
        logic expB, expL;
        qif.evt_valid = ev; qif.evt_addr = a; qif.bus_func_in = bop; qif.l2tol1msg_in = lm;
        qif.bus_out_ready = bRdy; qif.l1_out_ready = lRdy;
        expB = (busQ.size() != 0);
        expL = (l1Q.size() != 0);
        vecCount++;
        if (qif.bus_out_valid !== expB) begin
            missCount++; $display("[TB] FAIL bus_valid: got %0b want %0b", qif.bus_out_valid, expB);
        end
        vecCount++;
        if (qif.bus_full !== (busQ.size() == DEPTH)) begin
            missCount++; $display("[TB] FAIL bus_full: got %0b want %0b", qif.bus_full, busQ.size() == DEPTH);
        end
        vecCount++;
        if (qif.bus_drops !== CNT_W'(busDrops)) begin
            missCount++; $display("[TB] FAIL bus_drops: got %0d want %0d", qif.bus_drops, busDrops);
        end
        vecCount++;
        if (expB && (qif.bus_out_op !== busQ[0].op || qif.bus_out_addr !== busQ[0].addr)) begin
            missCount++; $display("[TB] FAIL bus_head: got %0d/%h want %0d/%h",
                                  qif.bus_out_op, qif.bus_out_addr, busQ[0].op, busQ[0].addr);
        end else if (!expB && (qif.bus_out_op !== NULL || qif.bus_out_addr !== '0)) begin
            missCount++; $display("[TB] FAIL bus_idle: got %0d/%h want 0/0", qif.bus_out_op, qif.bus_out_addr);
        end
        vecCount++;
        if (qif.l1_out_valid !== expL) begin
            missCount++; $display("[TB] FAIL l1_valid: got %0b want %0b", qif.l1_out_valid, expL);
        end
        vecCount++;
        if (qif.l1_full !== (l1Q.size() == DEPTH)) begin
            missCount++; $display("[TB] FAIL l1_full: got %0b want %0b", qif.l1_full, l1Q.size() == DEPTH);
        end
        vecCount++;
        if (qif.l1_drops !== CNT_W'(l1Drops)) begin
            missCount++; $display("[TB] FAIL l1_drops: got %0d want %0d", qif.l1_drops, l1Drops);
        end
        vecCount++;
        if (expL && (qif.l1_out_msg !== l1Q[0].msg || qif.l1_out_addr !== l1Q[0].addr)) begin
            missCount++; $display("[TB] FAIL l1_head: got %0d/%h want %0d/%h",
                                  qif.l1_out_msg, qif.l1_out_addr, l1Q[0].msg, l1Q[0].addr);
        end else if (!expL && (qif.l1_out_msg !== NULLMsg || qif.l1_out_addr !== '0)) begin
            missCount++; $display("[TB] FAIL l1_idle: got %0d/%h want 0/0", qif.l1_out_msg, qif.l1_out_addr);
        end
        if (bRdy && expB) void'(busQ.pop_front());
        if (lRdy && expL) void'(l1Q.pop_front());
        if (ev && bop != NULL) begin
            if (busQ.size() < DEPTH) busQ.push_back('{bop, a});
            else if (busDrops < MAX_DROPS) busDrops++;
        end
        if (ev && lm != NULLMsg) begin
            if (l1Q.size() < DEPTH) l1Q.push_back('{lm, a});
            else if (l1Drops < MAX_DROPS) l1Drops++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic bRdy, input logic lRdy);
        step(1'b0, '0, NULL, NULLMsg, bRdy, lRdy);
    endtask

    task automatic test_reset();
        vecCount++;
        if (qif.bus_out_valid !== 1'b0 || qif.l1_out_valid !== 1'b0) begin
            missCount++; $display("[TB] FAIL reset_valid: got %0b/%0b want 0/0", qif.bus_out_valid, qif.l1_out_valid);
        end
        vecCount++;
        if (qif.bus_full !== 1'b0 || qif.l1_full !== 1'b0) begin
            missCount++; $display("[TB] FAIL reset_full: got %0b/%0b want 0/0", qif.bus_full, qif.l1_full);
        end
        vecCount++;
        if (qif.bus_out_op !== NULL || qif.l1_out_msg !== NULLMsg || qif.bus_out_addr !== '0 || qif.l1_out_addr !== '0) begin
            missCount++; $display("[TB] FAIL reset_data: got %0d/%0d/%h/%h want 0/0/0/0",
                                  qif.bus_out_op, qif.l1_out_msg, qif.bus_out_addr, qif.l1_out_addr);
        end
        vecCount++;
        if (qif.bus_drops !== '0 || qif.l1_drops !== '0) begin
            missCount++; $display("[TB] FAIL reset_drops: got %0d/%0d want 0/0", qif.bus_drops, qif.l1_drops);
        end
    endtask

    task automatic test_single();
        step(1'b1, 32'h0000_1A40, WRITE, EVICTLINE, 1'b0, 1'b0);
        vecCount++;
        if (qif.bus_out_valid !== 1'b1 || qif.bus_out_op !== WRITE || qif.bus_out_addr !== 32'h1A40) begin
            missCount++; $display("[TB] FAIL single_bus: got %0b/%0d/%h want 1/2/1a40",
                                  qif.bus_out_valid, qif.bus_out_op, qif.bus_out_addr);
        end
        vecCount++;
        if (qif.l1_out_valid !== 1'b1 || qif.l1_out_msg !== EVICTLINE || qif.l1_out_addr !== 32'h1A40) begin
            missCount++; $display("[TB] FAIL single_l1: got %0b/%0d/%h want 1/4/1a40",
                                  qif.l1_out_valid, qif.l1_out_msg, qif.l1_out_addr);
        end
        idle(1'b1, 1'b1);
        vecCount++;
        if (qif.bus_out_valid !== 1'b0 || qif.l1_out_valid !== 1'b0) begin
            missCount++; $display("[TB] FAIL single_drain: got %0b/%0b want 0/0", qif.bus_out_valid, qif.l1_out_valid);
        end
    endtask

    task automatic test_null_filter();
        step(1'b1, 32'h80, READ, NULLMsg, 1'b0, 1'b0);
        vecCount++;
        if (qif.bus_out_valid !== 1'b1 || qif.l1_out_valid !== 1'b0) begin
            missCount++; $display("[TB] FAIL null_l1: got %0b/%0b want 1/0", qif.bus_out_valid, qif.l1_out_valid);
        end
        step(1'b1, 32'h84, NULL, SENDLINE, 1'b0, 1'b0);
        vecCount++;
        if (qif.l1_out_valid !== 1'b1 || qif.l1_out_msg !== SENDLINE || qif.bus_out_addr !== 32'h80) begin
            missCount++; $display("[TB] FAIL null_bus: got %0b/%0d/%h want 1/2/80",
                                  qif.l1_out_valid, qif.l1_out_msg, qif.bus_out_addr);
        end
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        logic [ADDR_W-1:0] expAddr;
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, ADDR_W'(i * 16), READ, NULLMsg, 1'b0, 1'b0);
            if (i == 4) begin
                vecCount++;
                if (qif.bus_full !== 1'b1) begin
                    missCount++; $display("[TB] FAIL ovf_full: got %0b want 1", qif.bus_full);
                end
            end
        end
        vecCount++;
        if (qif.bus_drops !== CNT_W'(2)) begin
            missCount++; $display("[TB] FAIL ovf_drops: got %0d want 2", qif.bus_drops);
        end
        for (int k = 0; k < 4; k++) begin
            expAddr = ADDR_W'((k + 1) * 16);
            vecCount++;
            if (qif.bus_out_addr !== expAddr) begin
                missCount++; $display("[TB] FAIL ovf_order: got %h want %h", qif.bus_out_addr, expAddr);
            end
            idle(1'b1, 1'b0);
        end
        vecCount++;
        if (qif.bus_out_valid !== 1'b0) begin
            missCount++; $display("[TB] FAIL ovf_empty: got %0b want 0", qif.bus_out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [ADDR_W-1:0] expAddr [4];
        expAddr = '{32'hA2, 32'hA3, 32'hA4, 32'h99};
        for (int i = 1; i <= 4; i++) step(1'b1, ADDR_W'(32'hA0 + i), INVALIDATE, NULLMsg, 1'b0, 1'b0);
        step(1'b1, 32'h99, RWIM, NULLMsg, 1'b1, 1'b0);
        vecCount++;
        if (qif.bus_full !== 1'b1 || qif.bus_drops !== CNT_W'(2)) begin
            missCount++; $display("[TB] FAIL fpp_state: got full=%0b drops=%0d want 1/2", qif.bus_full, qif.bus_drops);
        end
        for (int k = 0; k < 4; k++) begin
            vecCount++;
            if (qif.bus_out_addr !== expAddr[k]) begin
                missCount++; $display("[TB] FAIL fpp_order: got %h want %h", qif.bus_out_addr, expAddr[k]);
            end
            idle(1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) step(1'b1, ADDR_W'(32'h100 + i), READ, NULLMsg, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, ADDR_W'(32'h200 + i), WRITE, NULLMsg, 1'b0, 1'b0);
        vecCount++;
        if (qif.bus_drops !== CNT_W'(MAX_DROPS)) begin
            missCount++; $display("[TB] FAIL sat_drops: got %0d want %0d", qif.bus_drops, MAX_DROPS);
        end
        for (int i = 0; i < 12; i++) step(1'b1, ADDR_W'(32'h300 + i), WRITE, GETLINE, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);
        vecCount++;
        if (qif.bus_out_valid !== 1'b0 || qif.l1_out_valid !== 1'b0 || qif.l1_drops !== '0) begin
            missCount++; $display("[TB] FAIL b2b_end: got %0b/%0b/%0d want 0/0/0",
                                  qif.bus_out_valid, qif.l1_out_valid, qif.l1_drops);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, ADDR_W'(32'h500 + i), READ, SENDLINE, 1'b0, 1'b0);
        qif.bus_out_ready = 1'b1;
        qif.l1_out_ready  = 1'b1;
        #2 rst = 1'b1;
        #1;
        vecCount++;
        if (qif.bus_out_valid !== 1'b0 || qif.l1_out_valid !== 1'b0 || qif.bus_out_addr !== '0 ||
            qif.l1_out_addr !== '0 || qif.bus_out_op !== NULL || qif.l1_out_msg !== NULLMsg) begin
            missCount++; $display("[TB] FAIL arst_outputs: got %0b/%0b/%h/%h want 0/0/0/0",
                                  qif.bus_out_valid, qif.l1_out_valid, qif.bus_out_addr, qif.l1_out_addr);
        end
        vecCount++;
        if (qif.bus_drops !== '0) begin
            missCount++; $display("[TB] FAIL arst_drops: got %0d want 0", qif.bus_drops);
        end
        busQ.delete(); l1Q.delete(); busDrops = 0; l1Drops = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 32'h777, RWIM, INVALIDATELINE, 1'b0, 1'b0);
        vecCount++;
        if (qif.bus_out_addr !== 32'h777 || qif.bus_out_op !== RWIM || qif.l1_out_msg !== INVALIDATELINE) begin
            missCount++; $display("[TB] FAIL arst_fresh: got %h/%0d/%0d want 777/4/3",
                                  qif.bus_out_addr, qif.bus_out_op, qif.l1_out_msg);
        end
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);
    endtask

    initial begin
        vecCount = 0; missCount = 0; busDrops = 0; l1Drops = 0;
        rst = 1'b1;
        qif.evt_valid = 1'b0; qif.evt_addr = '0; qif.bus_func_in = NULL; qif.l2tol1msg_in = NULLMsg;
        qif.bus_out_ready = 1'b0; qif.l1_out_ready = 1'b0;
        #2;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released");
        test_single();
        test_null_filter();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d vectors applied", vecCount);
        $fatal(1, "[TB] timeout");
    end

endmodule
